half_word_sequencer: RTL and testbench
======================================

# half_word_sequencer

Sequences 32-bit address words onto a single 16-bit output channel, one half per beat: the instruction half (bits 31:16) first, then the absolute half (bits 15:0). The block sits between a word producer, such as a fetch unit or register file read port, and a narrow 16-bit consumer. Both sides use valid/ready handshakes, and one word is held internally. The block sustains one output beat per clock, which is one word every two cycles.

## Interface
- `HALF_W`, default 16: half-word width. The input word is 2*HALF_W bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous abort. Drops any held word and returns to IDLE.
- `in_valid`  in  1  the producer presents `in_word`.
- `in_ready`  out  1  the block accepts `in_word` this cycle.
- `in_word`  in  2*HALF_W  address word: instruction half in the upper bits, absolute half in the lower bits.
- `out_valid`  out  1  `out_half` and `out_kind` are valid.
- `out_ready`  in  1  the consumer takes the beat.
- `out_half`  out  HALF_W  current half-word.
- `out_kind`  out  1  0 = instruction half, 1 = absolute half.
- `out_last`  out  1  high on the absolute beat, which is the final beat of a word.
- `word_count`  out  16  completed words. Present only with `HWS_STATS_EN`.

## Operation
- Registers:
  - `word_q`, 2*HALF_W bits.
  - State register, one of IDLE, HI, LO.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - An accept (`in_valid` & `in_ready`) loads `word_q` and moves to HI.
- HI:
  - `out_valid`=1, `out_half`=`word_q[2*HALF_W-1:HALF_W]`, `out_kind`=0, `out_last`=0, `in_ready`=0.
  - `out_ready` moves to LO. Otherwise the block holds, and all outputs stay stable.
- LO:
  - `out_valid`=1, `out_half`=`word_q[HALF_W-1:0]`, `out_kind`=1, `out_last`=1.
  - `in_ready`=`out_ready`.
  - On `out_ready`: if `in_valid` is high, load the new word and go to HI (back-to-back). Otherwise go to IDLE.
  - Without `out_ready`: hold, and `in_ready` stays 0.
- `in_ready` is combinational from state, `out_ready` and `flush`. It never depends on `in_valid`.
- `flush`:
  - Highest priority. Forces `in_ready`=0 in the same cycle.
  - The next state is IDLE regardless of the handshakes.
  - A beat handshaken in the flush cycle counts as consumed, but no new word is loaded.
- Once `out_valid` rises, it stays high until `out_ready`. The exception is `flush`, which may drop it.
- Reset values: state=IDLE, `word_q`=0, `out_valid`=0, `out_half`=0, `out_kind`=0, `out_last`=0, `in_ready`=1 (combinational from IDLE), `word_count`=0.
- Reset mid-word: the held word is lost and `out_valid` drops immediately, asynchronously.

## Timing
- Latency: a word accepted at edge N gives its instruction beat valid after edge N, that is in cycle N+1.
- With `out_ready` held high, the absolute beat is in cycle N+2.
- Throughput: with `in_valid` and `out_ready` held high, the accepts land on every second edge. The output stream then runs I,A,I,A with no bubbles.
- Consumer stall: zero-cycle response, no extra latency when `out_ready` returns.
- No combinational path from `in_word` to any output.
- All outputs except `in_ready` are registered or derived from registers only.

## Configuration
- `HWS_STATS_EN` defined:
  - Adds the `word_count` port and a 16-bit counter.
  - The counter increments on every LO beat handshake (`out_valid` & `out_ready` & `out_last`), including one that coincides with `flush`.
  - It saturates at 0xFFFF.
  - It clears on `rst_n` only. `flush` does not clear it.
- Not defined: no port, no counter logic, no other behavioural difference.

## Test plan
- Reset, then `in_word`=0xF00F1010 with `in_valid` for one cycle and `out_ready`=1. Required response: cycle 1 `out_half`=0xF00F, `kind`=0, `last`=0; cycle 2 0x1010, `kind`=1, `last`=1; then `out_valid`=0.
- Stream 0xAAAA5555, 0x12345678, 0xDEADBEEF back-to-back with `out_ready`=1. Required response: six contiguous beats AAAA,5555,1234,5678,DEAD,BEEF, and `in_ready` high only in the IDLE/LO cycles.
- Hold `out_ready`=0 for 3 cycles in HI, then in LO, with random `in_valid`. Required response: outputs stable, `in_ready`=0 throughout the stalls, and no word lost or duplicated.
- Assert `flush` in HI holding 0xCAFE0001. Required response: next cycle IDLE, `out_valid`=0, and 0x0001 never emitted. Check the same with `flush` in LO coinciding with `in_valid`: the new word is not accepted.
- Deassert `rst_n` mid-word, asynchronously, not on an edge. Required response: `out_valid` falls at once, and after release `in_ready`=1 with all outputs 0.
- With `HWS_STATS_EN`: 5 complete words plus 1 flushed in HI gives `word_count`=5. Preload-force the counter to 0xFFFE, then complete 3 words: it reads 0xFFFF.

Source files
------------

// File: rtl/half_word_sequencer.sv
// Splits 32-bit address words into an instruction half then an absolute half on a 16-bit stream.
// Optional HWS_STATS_EN adds a saturating completed-word counter on port word_count.
module half_word_sequencer #(
    parameter int HALF_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*HALF_W-1:0] in_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [HALF_W-1:0]   out_half,
    output logic                out_kind,
    output logic                out_last
`ifdef HWS_STATS_EN
    ,
    output logic [15:0]         word_count
`endif
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t              state, state_nxt;
    logic [2*HALF_W-1:0] word_q;
    logic                load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // in_ready is a function of state, out_ready and flush only, never in_valid.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = HI;
            end
            HI: if (out_ready) state_nxt = LO;
            LO: begin
                in_ready = out_ready;
                if (out_ready) state_nxt = in_valid ? HI : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            in_ready  = 1'b0;
            state_nxt = IDLE;
        end
        load = in_valid & in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     word_q <= '0;
        else if (flush) word_q <= '0;
        else if (load)  word_q <= in_word;
    end

    assign out_valid = (state == HI) || (state == LO);
    assign out_kind  = (state == LO);
    assign out_last  = (state == LO);

    always_comb begin
        out_half = '0;
        if (state == HI)      out_half = word_q[2*HALF_W-1:HALF_W];
        else if (state == LO) out_half = word_q[HALF_W-1:0];
    end

`ifdef HWS_STATS_EN
    logic [15:0] count_q;

    // A final-beat handshake counts even when it coincides with flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else if (out_valid && out_ready && out_last && count_q != 16'hFFFF)
            count_q <= count_q + 16'd1;
    end

    assign word_count = count_q;
`endif

endmodule

// File: tb/tb_half_word_sequencer.sv
// Directed self-checking bench for half_word_sequencer; stats checks build only with HWS_STATS_EN.
module tb_half_word_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_half;
    logic        out_kind;
    logic        out_last;
`ifdef HWS_STATS_EN
    logic [15:0] word_count;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    half_word_sequencer #(.HALF_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_half(out_half),
        .out_kind(out_kind), .out_last(out_last)
`ifdef HWS_STATS_EN
        , .word_count(word_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output bundle packed as {valid, kind, last, half}.
    function automatic logic [18:0] obs();
        return {out_valid, out_kind, out_last, out_half};
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (obs() !== 19'h0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: got out=%h in_ready=%b, want out=0 in_ready=1", obs(), in_ready);
        end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_word = 32'hF00F1010; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL single_accept: in_ready=%b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (obs() !== {3'b100, 16'hF00F} || in_ready !== 1'b0) begin
            fails++; $display("FAIL single_hi: got %h in_ready=%b want %h in_ready=0", obs(), in_ready, {3'b100, 16'hF00F});
        end
        step();
        checks++;
        if (obs() !== {3'b111, 16'h1010} || in_ready !== 1'b1) begin
            fails++; $display("FAIL single_lo: got %h in_ready=%b want %h in_ready=1", obs(), in_ready, {3'b111, 16'h1010});
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL single_idle: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        logic [15:0] beats [6];
        words = '{32'hAAAA5555, 32'h12345678, 32'hDEADBEEF};
        beats = '{16'hAAAA, 16'h5555, 16'h1234, 16'h5678, 16'hDEAD, 16'hBEEF};
        out_ready = 1'b1; in_valid = 1'b1; in_word = words[0];
        #1;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_first_accept: in_ready=%b want 1", in_ready); end
        step();
        for (int i = 0; i < 6; i++) begin
            if (i / 2 + 1 < 3) begin in_valid = 1'b1; in_word = words[i/2+1]; end
            else               begin in_valid = 1'b0; in_word = 32'h0; end
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_half !== beats[i] || out_kind !== i[0] || out_last !== i[0]
                || in_ready !== i[0]) begin
                fails++;
                $display("FAIL b2b_beat%0d: got v=%b half=%h kind=%b last=%b in_ready=%b want v=1 half=%h kind=%b in_ready=%b",
                         i, out_valid, out_half, out_kind, out_last, in_ready, beats[i], i[0], i[0]);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_word = 32'h13572468; out_ready = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                in_valid = 1'($urandom_range(1)); in_word = $urandom; out_ready = 1'b0;
                #1;
                checks++;
                if (obs() !== (k == 0 ? {3'b100, 16'h1357} : {3'b111, 16'h2468}) || in_ready !== 1'b0) begin
                    fails++; $display("FAIL stall_%s_c%0d: got %h in_ready=%b", k == 0 ? "hi" : "lo", c, obs(), in_ready);
                end
                step();
            end
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            checks++;
            if (out_half !== (k == 0 ? 16'h1357 : 16'h2468) || in_ready !== k[0]) begin
                fails++; $display("FAIL stall_release%0d: half=%h in_ready=%b", k, out_half, in_ready);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_end: out_valid=%b want 0 (duplicate word)", out_valid); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_word = 32'hCAFE0001; out_ready = 1'b0;
        step();
        in_valid = 1'b0; flush = 1'b1;
        #1;
        checks++;
        if (out_half !== 16'hCAFE || in_ready !== 1'b0) begin
            fails++; $display("FAIL flush_hi_pre: half=%h in_ready=%b want CAFE/0", out_half, in_ready);
        end
        step();
        flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || out_half !== 16'h0) begin
                fails++; $display("FAIL flush_hi_after%0d: v=%b half=%h want 0/0000", c, out_valid, out_half);
            end
            step();
        end
        in_valid = 1'b1; in_word = 32'hBEEF0002;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1; in_valid = 1'b1; in_word = 32'h11112222;
        #1;
        checks++;
        if (out_half !== 16'h0002 || in_ready !== 1'b0) begin
            fails++; $display("FAIL flush_lo_pre: half=%h in_ready=%b want 0002/0", out_half, in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_lo_after: v=%b in_ready=%b want 0/1 (new word accepted)", out_valid, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_lo_idle: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_word = 32'h55AA33CC; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL async_reset_drop: out_valid=%b want 0", out_valid); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (obs() !== 19'h0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL async_reset_release: out=%h in_ready=%b want 0/1", obs(), in_ready);
        end
        step();
    endtask

`ifdef HWS_STATS_EN
    task automatic run_word(input logic [31:0] w);
        in_valid = 1'b1; in_word = w; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_stats();
        checks++;
        if (word_count !== 16'h0) begin fails++; $display("FAIL stats_reset: count=%h want 0000", word_count); end
        for (int i = 0; i < 5; i++) run_word(32'h00010002 * (i + 1));
        in_valid = 1'b1; in_word = 32'h77778888;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        checks++;
        if (word_count !== 16'd5) begin fails++; $display("FAIL stats_count: count=%0d want 5", word_count); end
        dut.count_q = 16'hFFFE;
        for (int i = 0; i < 3; i++) run_word(32'h9999AAAA);
        checks++;
        if (word_count !== 16'hFFFF) begin fails++; $display("FAIL stats_saturate: count=%h want FFFF", word_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
`ifdef HWS_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
